// File: rtl/edge_evt_pkg.sv
// Shared definitions for the edge event arbiter: edge mode encodings and
// the arbiter state type.
package edge_evt_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  typedef enum logic {
    IDLE,
    OFFER
  } arb_state_t;

endpackage

// File: rtl/edge_detect_ch.sv
// Single-channel edge detector: keeps the previous sample of x and emits
// one-cycle rise/fall pulses.
module edge_detect_ch (
  input  logic clk,
  input  logic x,
  output logic rise,
  output logic fall
);

  logic x_q;

  // x_q always follows x, including during reset, so no edge is seen on release
  always_ff @(posedge clk) begin
    x_q <= x;
  end

  assign rise = x & ~x_q;
  assign fall = ~x & x_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// Latches configured edges on N_CH inputs as sticky pending events and
// serves them one at a time over a valid/ready port with round-robin priority.
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int N_CH = 4,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   x,
  input  logic [N_CH-1:0]   ch_en,
  input  logic [2*N_CH-1:0] edge_mode,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CH_W-1:0]   evt_ch,
  output logic              evt_rise,
  output logic [N_CH-1:0]   pending,
  output logic [N_CH-1:0]   overflow,
  input  logic [N_CH-1:0]   ovf_clr
);

  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] det;
  logic [N_CH-1:0] pend_type;
  logic [N_CH-1:0] clr_vec;
  logic [N_CH-1:0] type_load;
  logic [N_CH-1:0] ovf_set;
  logic            hs;
  logic            sel_found;
  logic [CH_W-1:0] sel_ch;
  logic [CH_W-1:0] last_grant;
  arb_state_t      state;
  arb_state_t      state_nxt;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_detect_ch u_det (
      .clk  (clk),
      .x    (x[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );

    assign det[i] = ch_en[i] &
                    ((rise[i] & ((edge_mode[2*i +: 2] & MODE_RISE) != 2'b00)) |
                     (fall[i] & ((edge_mode[2*i +: 2] & MODE_FALL) != 2'b00)));
  end

  always_comb begin
    clr_vec = '0;
    if (hs) begin
      clr_vec[evt_ch] = 1'b1;
    end
  end

  // A detection in the handshake cycle re-arms the channel with the new type
  assign type_load = det & (~pending | clr_vec);
  assign ovf_set   = det & pending & ~clr_vec;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= '0;
      pend_type <= '0;
      overflow  <= '0;
    end else begin
      pending   <= (pending & ~clr_vec) | det;
      pend_type <= (pend_type & ~type_load) | (rise & type_load);
      overflow  <= ovf_set | (overflow & ~ovf_clr);
    end
  end

  // Round-robin pick: first pending channel after the last grant, with wrap
  always_comb begin
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_ch    = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(last_grant) + k) % N_CH;
      if (!sel_found && pending[idx]) begin
        sel_found = 1'b1;
        sel_ch    = CH_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_found) state_nxt = OFFER;
      OFFER:   if (hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    evt_valid = (state == OFFER);
    hs        = evt_valid & evt_ready;
  end

  // Offer payload is captured on entry to OFFER and held until accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      evt_ch     <= '0;
      evt_rise   <= 1'b0;
      last_grant <= CH_W'(N_CH - 1);
    end else begin
      if (state == IDLE && sel_found) begin
        evt_ch   <= sel_ch;
        evt_rise <= pend_type[sel_ch];
      end
      if (hs) begin
        last_grant <= evt_ch;
      end
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Randomized bench for edge_event_arbiter against a behavioural model of
// the pending/overflow rules and round-robin service order.
module tb_edge_event_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   x;
  logic [N-1:0]   ch_en;
  logic [2*N-1:0] edge_mode;
  logic           evt_valid;
  logic           evt_ready;
  logic [1:0]     evt_ch;
  logic           evt_rise;
  logic [N-1:0]   pending;
  logic [N-1:0]   overflow;
  logic [N-1:0]   ovf_clr;

  int vectors = 0;
  int miscompares = 0;

  logic [N-1:0] m_pend;
  logic [N-1:0] m_type;
  logic [N-1:0] m_ovf;
  logic [N-1:0] m_prev;
  int           m_last;
  bit           m_off;
  int           m_ch;
  bit           m_rise;

  edge_event_arbiter #(.N_CH(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .x         (x),
    .ch_en     (ch_en),
    .edge_mode (edge_mode),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_rise  (evt_rise),
    .pending   (pending),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge, from the pre-edge inputs and model state
  task automatic modelStep();
    logic [N-1:0] old_pend;
    logic [N-1:0] old_type;
    bit hs, r, f, want, cleared, set_ovf;
    int pick, idx;
    if (reset) begin
      m_pend = '0; m_type = '0; m_ovf = '0;
      m_off = 0; m_ch = 0; m_rise = 0; m_last = N - 1;
      m_prev = x;
      return;
    end
    old_pend = m_pend;
    old_type = m_type;
    hs = m_off && evt_ready;
    for (int i = 0; i < N; i++) begin
      r = x[i] && !m_prev[i];
      f = !x[i] && m_prev[i];
      want = ch_en[i] && ((r && edge_mode[2*i]) || (f && edge_mode[2*i+1]));
      cleared = hs && (m_ch == i);
      set_ovf = 0;
      if (want) begin
        if (!old_pend[i] || cleared) begin
          m_pend[i] = 1'b1;
          m_type[i] = r;
        end else begin
          set_ovf = 1;
        end
      end else if (cleared) begin
        m_pend[i] = 1'b0;
      end
      if (set_ovf) m_ovf[i] = 1'b1;
      else if (ovf_clr[i]) m_ovf[i] = 1'b0;
    end
    if (hs) begin
      m_off = 0;
      m_last = m_ch;
    end else if (!m_off) begin
      pick = -1;
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (pick < 0 && old_pend[idx]) pick = idx;
      end
      if (pick >= 0) begin
        m_off = 1;
        m_ch = pick;
        m_rise = old_type[pick];
      end
    end
    m_prev = x;
  endtask

  task automatic compareAll();
    checkOutput("evt_valid", 32'(evt_valid), 32'(m_off));
    checkOutput("evt_ch",    32'(evt_ch),    32'(m_ch));
    checkOutput("evt_rise",  32'(evt_rise),  32'(m_rise));
    checkOutput("pending",   32'(pending),   32'(m_pend));
    checkOutput("overflow",  32'(overflow),  32'(m_ovf));
  endtask

  task automatic applyStimulus(input logic r, input logic [N-1:0] xv, input logic [N-1:0] en,
                               input logic [2*N-1:0] mode, input logic rdy, input logic [N-1:0] oclr);
    reset = r; x = xv; ch_en = en; edge_mode = mode; evt_ready = rdy; ovf_clr = oclr;
    @(posedge clk);
    modelStep();
    #1;
    compareAll();
  endtask

  initial begin
    logic [N-1:0] xv, en, oclr;
    logic [2*N-1:0] mode;
    logic r, rdy;
    reset = 1'b1; x = '1; ch_en = '1; edge_mode = '1; evt_ready = 1'b0; ovf_clr = '0;

    // Reset with all inputs high, then a falling edge on channel 2
    applyStimulus(1, 4'b1111, 4'hF, 8'hFF, 0, 0);
    applyStimulus(0, 4'b1111, 4'hF, 8'hFF, 0, 0);
    applyStimulus(0, 4'b1111, 4'hF, 8'hFF, 0, 0);
    checkOutput("t1_quiet_valid", 32'(evt_valid), 32'd0);
    checkOutput("t1_quiet_pend", 32'(pending), 32'd0);
    applyStimulus(0, 4'b1011, 4'hF, 8'hFF, 0, 0);
    checkOutput("t1_pend", 32'(pending), 32'h4);
    checkOutput("t1_notyet", 32'(evt_valid), 32'd0);
    applyStimulus(0, 4'b1011, 4'hF, 8'hFF, 0, 0);
    checkOutput("t1_valid", 32'(evt_valid), 32'd1);
    checkOutput("t1_ch", 32'(evt_ch), 32'd2);
    checkOutput("t1_rise", 32'(evt_rise), 32'd0);

    // Reset mid-offer drops the event; ch0 wins the first post-reset grant
    applyStimulus(1, 4'b1011, 4'hF, 8'hFF, 0, 0);
    checkOutput("t6_valid", 32'(evt_valid), 32'd0);
    checkOutput("t6_pend", 32'(pending), 32'd0);
    applyStimulus(0, 4'b1011, 4'hF, 8'hFF, 0, 0);
    applyStimulus(0, 4'b1110, 4'hF, 8'hFF, 0, 0);
    checkOutput("t6_pend2", 32'(pending), 32'h5);
    applyStimulus(0, 4'b1110, 4'hF, 8'hFF, 0, 0);
    checkOutput("t6_ch", 32'(evt_ch), 32'd0);
    checkOutput("t6_rise", 32'(evt_rise), 32'd0);

    xv = 4'b1110; en = 4'hF; mode = 8'hFF;
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 299) == 0);
      xv = xv ^ (4'($urandom) & 4'($urandom));
      if ($urandom_range(0, 49) == 0) en = 4'($urandom);
      if ($urandom_range(0, 49) == 0) mode = 8'($urandom);
      rdy = ($urandom_range(0, 2) != 0);
      oclr = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
      applyStimulus(r, xv, en, mode, rdy, oclr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
